// File: rtl/tkx_unload_32b.sv
// 128-bit tweakey/state unloader: sends four 32-bit words MSW first
// over a valid/ready bus. Optional macro: TKX_UNLOAD_ZEROIZE_EN.
module tkx_unload_32b #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W*N-1:0] tkx_in,
    input  logic           load,
    input  logic           abort,
    output logic [W-1:0]   sdo,
    output logic           sdo_valid,
    input  logic           sdo_ready,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W*N-1:0]   r_sr;
    logic [W*N-1:0]   w_sr_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_valid;
    logic             w_xfer;
    logic             w_last;

    assign w_valid   = (r_state == SEND);
    assign w_xfer    = w_valid && sdo_ready;
    assign w_last    = (r_cnt == CW'(N - 1));

    assign sdo_valid = w_valid;
    assign sdo       = w_valid ? r_sr[W*N-1 -: W] : '0;
    assign busy      = w_valid;
    assign done      = r_done;

    // State, shift register, word counter and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: abort wins over everything, load only in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        if (abort) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
`ifdef TKX_UNLOAD_ZEROIZE_EN
            w_sr_nxt    = '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (load) begin
                        w_sr_nxt    = tkx_in;
                        w_cnt_nxt   = '0;
                        w_state_nxt = SEND;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        w_sr_nxt  = r_sr << W;
                        w_cnt_nxt = r_cnt + CW'(1);
                        if (w_last) begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                            w_done_nxt  = 1'b1;
`ifdef TKX_UNLOAD_ZEROIZE_EN
                            w_sr_nxt    = '0;
`endif
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tkx_unload_32b.sv
// Bench for tkx_unload_32b: vector table, directed corner cases,
// random traffic against a word-queue model, and loader loopback.
module tb_tkx_unload_32b;

    logic         clk;
    logic         rst;
    logic [127:0] tkx_in;
    logic         load;
    logic         abort;
    logic [31:0]  sdo;
    logic         sdo_valid;
    logic         sdo_ready;
    logic         busy;
    logic         done;

    tkx_unload_32b dut (
        .clk       (clk),
        .rst       (rst),
        .tkx_in    (tkx_in),
        .load      (load),
        .abort     (abort),
        .sdo       (sdo),
        .sdo_valid (sdo_valid),
        .sdo_ready (sdo_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] VA = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] VB = 128'hFFFFFFFF_00000000_12345678_9ABCDEF0;

    int n_cmp = 0;
    int n_err = 0;

    // 32-bit shift-in loader fed by accepted words
    logic [127:0] ld;
    always @(posedge clk) begin
        if (rst)
            ld <= '0;
        else if (sdo_valid && sdo_ready && !abort)
            ld <= {ld[95:0], sdo};
    end

    // reference model: queue of words still to be sent
    logic [31:0] mq[$];
    logic        m_done;

    task automatic model_step(input logic r, input logic a, input logic l,
                              input logic rdy, input logic [127:0] v);
        if (r || a) begin
            mq.delete();
            m_done = 1'b0;
        end else if (mq.size() != 0) begin
            m_done = 1'b0;
            if (rdy) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (l) begin
                for (int k = 3; k >= 0; k--) mq.push_back(v[k*32 +: 32]);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic a, input logic l,
                       input logic rdy, input logic [127:0] v);
        rst       = r;
        abort     = a;
        load      = l;
        sdo_ready = rdy;
        tkx_in    = v;
        @(posedge clk);
        model_step(r, a, l, rdy, v);
        #1;
    endtask

    function automatic logic [34:0] outs();
        return {sdo_valid, busy, done, sdo};
    endfunction

    function automatic logic [34:0] mouts();
        logic       mv;
        logic [31:0] mw;
        mv = (mq.size() != 0);
        mw = mv ? mq[0] : 32'h0;
        return {mv, mv, m_done, mw};
    endfunction

    typedef struct {
        logic         r;
        logic         a;
        logic         l;
        logic         rdy;
        logic [127:0] v;
        logic         ev;
        logic [31:0]  ew;
        logic         eb;
        logic         ed;
    } vec_t;

    vec_t tbl[21];

    initial begin
        logic [31:0]  wa[4];
        logic [127:0] rv;
        logic         got;

        rst = 1'b1; abort = 1'b0; load = 1'b0;
        sdo_ready = 1'b0; tkx_in = '0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 128'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, VA, 1'b1, 32'h00112233, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, VB, 1'b1, 32'h44556677, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, VB, 1'b1, 32'h8899AABB, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, VB, 1'b1, 32'hCCDDEEFF, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, VB, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, VB, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, VA, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, VA, 1'b1, 32'h12345678, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, VA, 1'b1, 32'h9ABCDEF0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, VA, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, VA, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, VA, 1'b1, 32'h00112233, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, VB, 1'b1, 32'h00112233, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, VB, 1'b1, 32'h44556677, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, VB, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, VB, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, VB, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, VA, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b1, VA, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b1, VA, 1'b0, 32'h0, 1'b0, 1'b0};

        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].r, tbl[i].a, tbl[i].l, tbl[i].rdy, tbl[i].v);
            chk($sformatf("vec%0d", i), {93'h0, outs()},
                {93'h0, tbl[i].ev, tbl[i].eb, tbl[i].ed, tbl[i].ew});
        end

        // backpressure: 3 stall cycles before each acceptance
        wa[0] = 32'h00112233; wa[1] = 32'h44556677;
        wa[2] = 32'h8899AABB; wa[3] = 32'hCCDDEEFF;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, VA);
        for (int w = 0; w < 4; w++) begin
            for (int s = 0; s < 3; s++) begin
                chk($sformatf("stall w%0d s%0d", w, s),
                    {95'h0, sdo_valid, sdo}, {95'h0, 1'b1, wa[w]});
                cyc(1'b0, 1'b0, s == 1, 1'b0, VB);
            end
            chk($sformatf("stall acc w%0d", w),
                {95'h0, sdo_valid, sdo}, {95'h0, 1'b1, wa[w]});
            cyc(1'b0, 1'b0, 1'b0, 1'b1, VB);
        end
        chk("stall done", {126'h0, done, busy}, {126'h0, 1'b1, 1'b0});
        cyc(1'b0, 1'b0, 1'b0, 1'b0, VB);
        chk("stall after", {127'h0, done | sdo_valid}, 128'h0);

        // abort after two words, then probe the shift register
        cyc(1'b0, 1'b0, 1'b1, 1'b0, VA);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, VA);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, VA);
        chk("pre abort", {96'h0, sdo}, {96'h0, 32'h8899AABB});
        cyc(1'b0, 1'b1, 1'b0, 1'b1, VA);
        chk("abort outs", {93'h0, outs()}, 128'h0);
`ifdef TKX_UNLOAD_ZEROIZE_EN
        chk("abort sr", dut.r_sr, 128'h0);
`else
        chk("abort sr", dut.r_sr, VA << 64);
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b1, VA);
        chk("abort nodone", {93'h0, outs()}, 128'h0);

        // random traffic against the queue model
        for (int t = 0; t < 3000; t++) begin
            rv = {$urandom, $urandom, $urandom, $urandom};
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, rv);
            chk("rand", {93'h0, outs()}, {93'h0, mouts()});
        end

        // loopback into the shift-in loader
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 128'h0);
        for (int k = 0; k < 100; k++) begin
            rv = {$urandom, $urandom, $urandom, $urandom};
            cyc(1'b0, 1'b0, 1'b1, $urandom_range(0, 1) == 1, rv);
            got = 1'b0;
            for (int t = 0; t < 64 && !got; t++) begin
                cyc(1'b0, 1'b0, 1'b0, $urandom_range(0, 1) == 1, 128'h0);
                if (done) got = 1'b1;
            end
            chk($sformatf("loop%0d timeout", k), {127'h0, got}, 128'h1);
            chk($sformatf("loop%0d", k), ld, rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
